// File: rtl/lvds_link_pkg.sv
// Shared definitions for the LVDS link bring-up controller: state encoding,
// default training word, registered-output bundle and width helpers.
package lvds_link_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_PLL_RST   = 3'd1,
      S_WAIT_LOCK = 3'd2,
      S_SETTLE    = 3'd3,
      S_ALIGN     = 3'd4,
      S_SLIP_WAIT = 3'd5,
      S_LINKED    = 3'd6,
      S_FAIL      = 3'd7
   } link_state_t;

   // x6 training word the deserializer should present once word-aligned
   localparam logic [5:0] TRAIN_PATTERN_DEFAULT = 6'b111000;

   // A 6-bit word has six bit phases; trying all of them exhausts alignment
   localparam int PHASE_COUNT = 6;

   typedef struct packed {
      logic pll_rst;
      logic serdes_rst;
      logic bitslip;
      logic link_up;
      logic link_fail;
   } link_out_t;

   localparam link_out_t OUT_RESET = '{pll_rst:    1'b1,
                                       serdes_rst: 1'b1,
                                       bitslip:    1'b0,
                                       link_up:    1'b0,
                                       link_fail:  1'b0};

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // Bits needed to hold values 0..max_val
   function automatic int cnt_width(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level (PLL lock).
module sync_2ff (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Shift the asynchronous level through two flops to resolve metastability
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make both flops sample the old values,
         // giving a real two-stage chain; blocking would collapse it to one flop.
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/lvds_link_ctrl.sv
// LVDS receive link bring-up: PLL reset and lock qualification, deserializer
// release, bitslip word alignment against a training pattern, bounded retries.
module lvds_link_ctrl
   import lvds_link_pkg::*;
#(
   parameter int         PLL_RST_CYCLES     = 16,
   parameter int         LOCK_STABLE_CYCLES = 1024,
   parameter int         LOCK_TIMEOUT       = 65535,
   parameter int         SETTLE_CYCLES      = 64,
   parameter logic [5:0] TRAIN_PATTERN      = TRAIN_PATTERN_DEFAULT,
   parameter int         MATCH_COUNT        = 16,
   parameter int         SLIP_WAIT_CYCLES   = 4,
   parameter int         MAX_RETRIES        = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       pll_locked,
   input  logic [5:0] rx_word,
   output logic       pll_rst,
   output logic       serdes_rst,
   output logic       bitslip,
   output logic       link_up,
   output logic       link_fail,
   output logic [2:0] state
);

   // One shared per-state cycle counter covers every timed state
   localparam int CYC_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                    max_int(SETTLE_CYCLES, SLIP_WAIT_CYCLES));
   localparam int CW = cnt_width(CYC_MAX);
   localparam int LW = cnt_width(LOCK_STABLE_CYCLES);
   localparam int MW = cnt_width(MATCH_COUNT);
   localparam int RW = cnt_width(MAX_RETRIES);

   localparam logic [CW-1:0] PLL_LAST     = CW'(PLL_RST_CYCLES - 1);
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
   localparam logic [CW-1:0] SETTLE_LAST  = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] SLIP_LAST    = CW'(SLIP_WAIT_CYCLES - 1);
   localparam logic [LW-1:0] LOCK_LAST    = LW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [MW-1:0] MATCH_LAST   = MW'(MATCH_COUNT - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
   localparam logic [2:0]    SLIP_LIMIT   = 3'(PHASE_COUNT);

   link_state_t   state_q, state_nxt;
   logic [CW-1:0] cyc_q, cyc_nxt;
   logic [LW-1:0] lock_q, lock_nxt;
   logic [MW-1:0] match_q, match_nxt;
   logic [2:0]    slip_q, slip_nxt;
   logic [RW-1:0] retry_q, retry_nxt;
   link_out_t     out_q, out_nxt;
   logic          lock_sync;
   logic          retry_evt;

   sync_2ff u_lock_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (pll_locked),
      .q     (lock_sync)
   );

   // Next-state, counter updates and decode of the registered outputs
   always_comb begin
      // NOTE: every signal gets a default before any branch, so no path can
      // leave one unassigned and infer a latch.
      state_nxt = state_q;
      cyc_nxt   = cyc_q + 1'b1;
      lock_nxt  = lock_q;
      match_nxt = match_q;
      slip_nxt  = slip_q;
      retry_nxt = retry_q;
      retry_evt = 1'b0;
      out_nxt   = OUT_RESET;

      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_nxt = S_PLL_RST;
               retry_nxt = '0;
            end
            S_PLL_RST: begin
               if (cyc_q == PLL_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
               // Lock must be continuously high; any low restarts the run
               lock_nxt = lock_sync ? lock_q + 1'b1 : '0;
               if (lock_sync && lock_q == LOCK_LAST) state_nxt = S_SETTLE;
               else if (cyc_q == TIMEOUT_LAST)       retry_evt = 1'b1;
            end
            S_SETTLE: begin
               if (cyc_q == SETTLE_LAST) begin
                  state_nxt = S_ALIGN;
                  slip_nxt  = '0;
                  match_nxt = '0;
               end
            end
            S_ALIGN: begin
               if (rx_word == TRAIN_PATTERN) begin
                  match_nxt = match_q + 1'b1;
                  if (match_q == MATCH_LAST) state_nxt = S_LINKED;
               end else begin
                  match_nxt = '0;
                  // Every phase already tried: a further slip cannot help
                  if (slip_q == SLIP_LIMIT) begin
                     retry_evt = 1'b1;
                  end else begin
                     out_nxt.bitslip = 1'b1;
                     slip_nxt        = slip_q + 1'b1;
                     state_nxt       = S_SLIP_WAIT;
                  end
               end
            end
            S_SLIP_WAIT: begin
               if (cyc_q == SLIP_LAST) state_nxt = S_ALIGN;
            end
            S_LINKED: begin
               // Lock loss is a fresh bring-up, not a failed attempt
               if (!lock_sync) begin
                  state_nxt = S_PLL_RST;
                  retry_nxt = '0;
               end
            end
            S_FAIL: begin
               state_nxt = S_FAIL;
            end
            default: state_nxt = S_IDLE;
         endcase
      end

      if (retry_evt) begin
         retry_nxt = retry_q + 1'b1;
         state_nxt = (retry_q + 1'b1 == RETRY_LIMIT) ? S_FAIL : S_PLL_RST;
      end

      // Per-state timers restart on every transition
      if (state_nxt != state_q) begin
         cyc_nxt  = '0;
         lock_nxt = '0;
      end

      if (state_nxt == S_IDLE) begin
         cyc_nxt   = '0;
         lock_nxt  = '0;
         match_nxt = '0;
         slip_nxt  = '0;
         retry_nxt = '0;
      end

      // Outputs are decoded from the state being entered, then registered
      out_nxt.pll_rst    = state_nxt inside {S_IDLE, S_PLL_RST, S_FAIL};
      out_nxt.serdes_rst = state_nxt inside {S_IDLE, S_PLL_RST, S_WAIT_LOCK, S_FAIL};
      out_nxt.link_up    = (state_nxt == S_LINKED);
      out_nxt.link_fail  = (state_nxt == S_FAIL);
   end

   // State, counters and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cyc_q   <= '0;
         lock_q  <= '0;
         match_q <= '0;
         slip_q  <= '0;
         retry_q <= '0;
         out_q   <= OUT_RESET;
      end else begin
         state_q <= state_nxt;
         cyc_q   <= cyc_nxt;
         lock_q  <= lock_nxt;
         match_q <= match_nxt;
         slip_q  <= slip_nxt;
         retry_q <= retry_nxt;
         out_q   <= out_nxt;
      end
   end

   assign pll_rst    = out_q.pll_rst;
   assign serdes_rst = out_q.serdes_rst;
   assign bitslip    = out_q.bitslip;
   assign link_up    = out_q.link_up;
   assign link_fail  = out_q.link_fail;
   assign state      = state_q;

endmodule

// File: tb/tb_lvds_link_ctrl.sv
// Bench for lvds_link_ctrl: behavioural PLL and deserializer models drive the
// DUT; expected timings come from phase durations summed arithmetically.
module tb_lvds_link_ctrl;

   localparam int T_PLL    = 16;
   localparam int SYNC_LAT = 2;
   localparam int T_STABLE = 1024;
   localparam int T_SETTLE = 64;
   localparam int N_MATCH  = 16;
   localparam int T_SLIP   = 4;
   localparam int PHASES   = 6;
   localparam int ATTEMPTS = 3;
   localparam logic [5:0] TRAIN = 6'b111000;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_PLL_RST = 3'd1, ST_WAIT_LOCK = 3'd2,
                          ST_SETTLE = 3'd3, ST_ALIGN = 3'd4, ST_LINKED = 3'd6,
                          ST_FAIL = 3'd7;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic       pll_locked;
   logic [5:0] rx_word;
   logic       pll_rst, serdes_rst, bitslip, link_up, link_fail;
   logic [2:0] state;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // PLL model controls
   int   lock_delay = 20;
   int   lock_ctr   = 0;
   logic auto_lock  = 1'b0;
   logic pll_manual = 1'b0;
   logic man_lock   = 1'b0;

   // Deserializer model controls
   int   rot      = 0;
   logic no_match = 1'b0;
   int   phase    = 0;
   int   garble   = 0;

   // Monitor statistics (only the monitor writes these)
   int         slip_pulses = 0;
   int         slip_close  = 0;
   int         slip_wide   = 0;
   int         pll_entries = 0;
   int         last_slip   = -100;
   logic       prev_slip   = 1'b0;
   logic [2:0] prev_state  = 3'd0;

   lvds_link_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .pll_locked (pll_locked),
      .rx_word    (rx_word),
      .pll_rst    (pll_rst),
      .serdes_rst (serdes_rst),
      .bitslip    (bitslip),
      .link_up    (link_up),
      .link_fail  (link_fail),
      .state      (state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   assign pll_locked = pll_manual ? man_lock : auto_lock;

   // PLL: loses lock while reset, locks lock_delay cycles after reset release
   always @(negedge clk) begin
      if (pll_rst) begin
         auto_lock = 1'b0;
         lock_ctr  = 0;
      end else if (lock_ctr < lock_delay) begin
         lock_ctr++;
      end else begin
         auto_lock = 1'b1;
      end
   end

   function automatic logic [5:0] rotl6(input logic [5:0] w, input int k);
      logic [5:0] r;
      r = w;
      for (int i = 0; i < k; i++) r = {r[4:0], r[5]};
      return r;
   endfunction

   // Deserializer: word rotated by phase; each bitslip undoes one rotation
   // after a few cycles of unpredictable output
   always @(negedge clk) begin
      if (serdes_rst) begin
         phase  = rot;
         garble = 0;
      end else if (bitslip) begin
         phase  = (phase + PHASES - 1) % PHASES;
         garble = 3;
      end
      if (no_match) begin
         rx_word = 6'b101010;
      end else if (garble > 0) begin
         rx_word = 6'($urandom);
         garble--;
      end else begin
         rx_word = rotl6(TRAIN, phase);
      end
   end

   // Bitslip pulse width/spacing and PLL_RST entry counting
   always @(negedge clk) begin
      if (bitslip === 1'b1) begin
         slip_pulses++;
         if (cyc - last_slip < 1 + T_SLIP) slip_close++;
         if (prev_slip === 1'b1) slip_wide++;
         last_slip = cyc;
      end
      if (state === ST_PLL_RST && prev_state !== ST_PLL_RST) pll_entries++;
      prev_slip  = bitslip;
      prev_state = state;
   end

   // Slips needed: undo rotations until the training word appears
   function automatic int slips_needed(input int r);
      logic [5:0] w;
      int n;
      w = rotl6(TRAIN, r);
      n = 0;
      while (w != TRAIN && n < PHASES) begin
         w = {w[0], w[5:1]};
         n++;
      end
      return n;
   endfunction

   // Clock edges from enable (or reset release) to link_up
   function automatic int bringup_cycles(input int d, input int r);
      return 1 + T_PLL + d + SYNC_LAT + T_STABLE + T_SETTLE
             + slips_needed(r) * (1 + T_SLIP) + N_MATCH;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int obs, input int lo, input int hi);
      checks++;
      assert (obs >= lo && obs <= hi) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d..%0d", tag, obs, lo, hi);
      end
   endtask

   // Wait at negedges until state reaches s; returns clock edges elapsed
   task automatic wait_state(input logic [2:0] s, input int budget, input string tag,
                             output int edges);
      edges = 0;
      while (state !== s && edges < budget) begin
         @(negedge clk);
         edges++;
      end
      checks++;
      assert (state === s) else begin
         failures++;
         $error("FAIL %s: observed state=%0d expected=%0d within %0d cycles",
                tag, state, s, budget);
      end
   endtask

   initial begin
      int t, d, r, bp, bc, bw, be;

      // Reset state
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_state", state, ST_IDLE);
      check("rst_pll_rst", pll_rst, 1'b1);
      check("rst_serdes_rst", serdes_rst, 1'b1);
      check("rst_bitslip", bitslip, 1'b0);
      check("rst_link_up", link_up, 1'b0);
      check("rst_link_fail", link_fail, 1'b0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_hold", state, ST_IDLE);

      // Nominal bring-up, aligned word, lock 20 cycles after pll_rst falls
      lock_delay = 20;
      rot        = 0;
      bp         = slip_pulses;
      enable     = 1'b1;
      wait_state(ST_LINKED, 3000, "nominal_link", t);
      check_range("nominal_link_time", t, bringup_cycles(20, 0) - 2, bringup_cycles(20, 0) + 2);
      check("nominal_link_up", link_up, 1'b1);
      check("nominal_pll_rst", pll_rst, 1'b0);
      check("nominal_serdes_rst", serdes_rst, 1'b0);
      check("nominal_no_slips", slip_pulses - bp, 0);

      // Mismatching words while linked are ignored
      no_match = 1'b1;
      repeat (20) @(negedge clk);
      check("linked_ignore_state", state, ST_LINKED);
      check("linked_ignore_link_up", link_up, 1'b1);
      check("linked_ignore_slips", slip_pulses - bp, 0);
      no_match = 1'b0;

      // Lock loss while linked: link_up falls once the loss is synchronized
      man_lock   = 1'b1;
      pll_manual = 1'b1;
      @(negedge clk);
      man_lock = 1'b0;
      rot      = 2;
      repeat (2) @(negedge clk);
      check("lockloss_link_up_hold", link_up, 1'b1);
      @(negedge clk);
      check("lockloss_link_up", link_up, 1'b0);
      check("lockloss_pll_rst", pll_rst, 1'b1);
      check("lockloss_state", state, ST_PLL_RST);

      // PLL reset duration, then a one-cycle lock glitch near count 1000
      wait_state(ST_WAIT_LOCK, 100, "relock_wait", t);
      check("pll_rst_cycles", t, T_PLL);
      check("wait_lock_pll_rst", pll_rst, 1'b0);
      check("wait_lock_serdes_rst", serdes_rst, 1'b1);
      bp = slip_pulses; bc = slip_close; bw = slip_wide;
      man_lock = 1'b1;
      repeat (1000) @(negedge clk);
      man_lock = 1'b0;
      @(negedge clk);
      man_lock = 1'b1;
      wait_state(ST_SETTLE, 3000, "glitch_settle", t);
      check("glitch_restart_cycles", t, SYNC_LAT + T_STABLE);
      check("settle_serdes_rst", serdes_rst, 1'b0);

      // Word rotated by 2: two spaced single-cycle slips, then link
      wait_state(ST_LINKED, 500, "rot2_link", t);
      check("rot2_align_cycles", t, T_SETTLE + slips_needed(2) * (1 + T_SLIP) + N_MATCH);
      check("rot2_slip_count", slip_pulses - bp, 2);
      check("rot2_slip_spacing", slip_close - bc, 0);
      check("rot2_slip_width", slip_wide - bw, 0);

      // enable low from LINKED returns to IDLE on the next cycle
      enable = 1'b0;
      @(negedge clk);
      check("disable_linked_state", state, ST_IDLE);
      pll_manual = 1'b0;

      // enable low during ALIGN
      r = $urandom_range(1, 5);
      rot        = r;
      lock_delay = $urandom_range(5, 40);
      enable     = 1'b1;
      wait_state(ST_ALIGN, 3000, "reach_align_1", t);
      enable = 1'b0;
      @(negedge clk);
      check("disable_align_state", state, ST_IDLE);
      check("disable_align_pll_rst", pll_rst, 1'b1);
      check("disable_align_serdes_rst", serdes_rst, 1'b1);
      check("disable_align_bitslip", bitslip, 1'b0);

      // Fresh bring-up after disable, random rotation and lock delay
      r = $urandom_range(0, 5);
      d = $urandom_range(5, 40);
      rot        = r;
      lock_delay = d;
      enable     = 1'b1;
      wait_state(ST_LINKED, 3000, "rand_link", t);
      check_range("rand_link_time", t, bringup_cycles(d, r) - 2, bringup_cycles(d, r) + 2);

      // Asynchronous reset during ALIGN, then bring-up restarts from IDLE
      enable = 1'b0;
      @(negedge clk);
      rot    = $urandom_range(1, 5);
      enable = 1'b1;
      wait_state(ST_ALIGN, 3000, "reach_align_2", t);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_state", state, ST_IDLE);
      check("async_rst_pll_rst", pll_rst, 1'b1);
      check("async_rst_serdes_rst", serdes_rst, 1'b1);
      check("async_rst_bitslip", bitslip, 1'b0);
      r = $urandom_range(0, 5);
      d = $urandom_range(5, 40);
      rot        = r;
      lock_delay = d;
      @(negedge clk);
      rst_n = 1'b1;
      wait_state(ST_LINKED, 3000, "rst_restart_link", t);
      check_range("rst_restart_time", t, bringup_cycles(d, r) - 2, bringup_cycles(d, r) + 2);

      // Word never matches: six slips per attempt, then FAIL after the attempts
      enable = 1'b0;
      @(negedge clk);
      no_match = 1'b1;
      bp = slip_pulses; bw = slip_wide; be = pll_entries;
      enable = 1'b1;
      wait_state(ST_FAIL, 8000, "fail_reach", t);
      check("fail_slip_count", slip_pulses - bp, PHASES * ATTEMPTS);
      check("fail_attempts", pll_entries - be, ATTEMPTS);
      check("fail_slip_width", slip_wide - bw, 0);
      check("fail_link_fail", link_fail, 1'b1);
      check("fail_pll_rst", pll_rst, 1'b1);
      check("fail_serdes_rst", serdes_rst, 1'b1);
      check("fail_link_up", link_up, 1'b0);
      repeat (10) @(negedge clk);
      check("fail_sticky", state, ST_FAIL);
      enable = 1'b0;
      @(negedge clk);
      check("fail_exit_state", state, ST_IDLE);
      check("fail_exit_link_fail", link_fail, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/lvds_link_ctrl.md
LVDS_LINK_CTRL -- requirements
Module: lvds_link_ctrl

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held asserted per attempt.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-lock cycles required.
REQ-003 SHALL have parameter LOCK_TIMEOUT, default 65535: maximum cycles spent in WAIT_LOCK.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 64: wait after serdes_rst release.
REQ-005 SHALL have parameter TRAIN_PATTERN, default 6'b111000: expected x6 training word.
REQ-006 SHALL have parameter MATCH_COUNT, default 16: consecutive matches required to declare link.
REQ-007 SHALL have parameter SLIP_WAIT_CYCLES, default 4: deserializer latency after a bitslip.
REQ-008 SHALL have parameter MAX_RETRIES, default 3: full PLL re-attempts before FAIL.
REQ-009 SHALL have port clk, input, 1: free-running fabric clock, not a PLL output.
REQ-010 SHALL have port rst_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-011 SHALL have port enable, input, 1: link bring-up request.
REQ-012 SHALL have port pll_locked, input, 1: PLL lock, asynchronous.
REQ-013 SHALL have port rx_word, input, 6: deserialized word, synchronous to clk.
REQ-014 SHALL have port pll_rst, output, 1: active-high PLL reset.
REQ-015 SHALL have port serdes_rst, output, 1: active-high deserializer reset.
REQ-016 SHALL have port bitslip, output, 1: single-cycle slip pulse.
REQ-017 SHALL have port link_up, output, 1: alignment achieved.
REQ-018 SHALL have port link_fail, output, 1: retries exhausted.
REQ-019 SHALL have port state, output, 3: current FSM state encoding.

Function
REQ-020 SHALL pass pll_locked through a 2-flop synchronizer; all lock decisions SHALL use the synchronized value.
REQ-021 SHALL implement states IDLE=0, PLL_RST=1, WAIT_LOCK=2, SETTLE=3, ALIGN=4, SLIP_WAIT=5, LINKED=6, FAIL=7.
REQ-022 IDLE: pll_rst=1, serdes_rst=1; enable=1 SHALL go to PLL_RST and clear the retry counter.
REQ-023 PLL_RST: pll_rst=1 for exactly PLL_RST_CYCLES cycles, then go to WAIT_LOCK.
REQ-024 WAIT_LOCK: count consecutive synchronized-lock cycles and reset the count on any low; on reaching LOCK_STABLE_CYCLES go to SETTLE; after LOCK_TIMEOUT cycles go to retry.
REQ-025 SETTLE: serdes_rst=0 from entry; after SETTLE_CYCLES go to ALIGN with the slip counter cleared.
REQ-026 ALIGN: rx_word==TRAIN_PATTERN SHALL increment the match counter; on reaching MATCH_COUNT go to LINKED.
REQ-027 In ALIGN, a mismatch SHALL clear the match counter, assert bitslip for exactly one cycle, increment the slip counter and go to SLIP_WAIT.
REQ-028 SLIP_WAIT: rx_word SHALL be ignored for SLIP_WAIT_CYCLES cycles, then return to ALIGN.
REQ-029 When the slip counter reaches 6 (all phases tried) on a mismatch, no bitslip SHALL be issued; go to retry instead.
REQ-030 Retry: increment the retry counter, then go to PLL_RST; if the retry counter equals MAX_RETRIES, go to FAIL instead.
REQ-031 LINKED: link_up=1; loss of synchronized lock SHALL go to PLL_RST (retry counter cleared); rx_word mismatches SHALL be ignored.
REQ-032 FAIL: link_fail=1, pll_rst=1, serdes_rst=1; exit only via enable=0.
REQ-033 enable=0 in any state SHALL go to IDLE on the next cycle, with priority over all other transitions.
REQ-034 serdes_rst SHALL be 1 in IDLE, PLL_RST, WAIT_LOCK and FAIL; pll_rst SHALL be 0 in WAIT_LOCK through LINKED.
REQ-035 All outputs SHALL be registered; link_up SHALL fall on the cycle after lock loss is seen synchronized.

Reset
REQ-036 rst_n low SHALL asynchronously force IDLE, pll_rst=1, serdes_rst=1, bitslip=0, link_up=0, link_fail=0, state=0, and clear all counters and synchronizer flops.
REQ-037 Reset deassertion mid-operation SHALL restart bring-up from IDLE.

Structure
REQ-038 State encodings and the default TRAIN_PATTERN SHALL reside in shared package lvds_link_pkg.
REQ-039 The lock synchronizer SHALL be the sub-module sync_2ff; everything else SHALL be one FSM with counters.

Verification
REQ-040 Scenario: enable=1, lock high 20 cycles after pll_rst falls, aligned pattern -> link_up=1 after 16+2+20+1024+64+16 cycles ±2.
REQ-041 Scenario: rx_word rotated by 2 -> exactly 2 single-cycle bitslip pulses, each separated by at least 5 cycles, then link_up=1.
REQ-042 Scenario: rx_word never matches -> 6 slips per attempt, 3 attempts -> link_fail=1, state=7.
REQ-043 Scenario: pll_locked low for 1 cycle at count 1000 in WAIT_LOCK -> the count restarts, no SETTLE entry.
REQ-044 Scenario: pll_locked drops in LINKED -> link_up=0 within 3 cycles, pll_rst=1, state=1.
REQ-045 Scenario: enable=0 or rst_n=0 during ALIGN -> IDLE, pll_rst=1, serdes_rst=1, counters cleared.
